// File: rtl/corereset_sdif_apb_arb.sv
// Round-robin arbiter sharing the SDIF APB target between the fabric init
// master (requester 0) and the user master (requester 1), with a forced idle gap.
module corereset_sdif_apb_arb #(
    parameter int          ADDR_W  = 16,
    parameter int          MIN_GAP = 4,
    parameter logic [7:0]  TIMEOUT = 8'd255
) (
    input  logic              CLK_BASE,
    input  logic              RESET,
    input  logic              hold_off,
    input  logic              req0,
    input  logic              req1,
    input  logic              write0,
    input  logic              write1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [31:0]       wdata0,
    input  logic [31:0]       wdata1,
    output logic              done0,
    output logic              done1,
    output logic              err,
    output logic [31:0]       rdata,
    output logic              busy,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [31:0]       pwdata,
    input  logic [31:0]       prdata,
    input  logic              pready,
    input  logic              pslverr
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, GAP} state_t;

    localparam logic [3:0] GAP_LOAD = 4'(MIN_GAP - 1);
    localparam logic [7:0] TO_LAST  = TIMEOUT - 8'd1;

    state_t            state, state_nx;
    logic              last_grant, last_grant_nx;
    logic              win;
    logic [7:0]        tcount, tcount_nx;
    logic [3:0]        gcount, gcount_nx;
    logic              done0_nx, done1_nx, err_nx, busy_nx;
    logic              psel_nx, penable_nx, pwrite_nx;
    logic [ADDR_W-1:0] paddr_nx;
    logic [31:0]       pwdata_nx, rdata_nx;

    always_ff @(posedge CLK_BASE or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            tcount     <= 8'd0;
            gcount     <= 4'd0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b0;
            psel       <= 1'b0;
            penable    <= 1'b0;
            pwrite     <= 1'b0;
            paddr      <= '0;
            pwdata     <= 32'd0;
            rdata      <= 32'd0;
        end else begin
            state      <= state_nx;
            last_grant <= last_grant_nx;
            tcount     <= tcount_nx;
            gcount     <= gcount_nx;
            done0      <= done0_nx;
            done1      <= done1_nx;
            err        <= err_nx;
            busy       <= busy_nx;
            psel       <= psel_nx;
            penable    <= penable_nx;
            pwrite     <= pwrite_nx;
            paddr      <= paddr_nx;
            pwdata     <= pwdata_nx;
            rdata      <= rdata_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        last_grant_nx = last_grant;
        win           = 1'b0;
        tcount_nx     = tcount;
        gcount_nx     = gcount;
        done0_nx      = 1'b0;
        done1_nx      = 1'b0;
        err_nx        = 1'b0;
        psel_nx       = psel;
        penable_nx    = penable;
        pwrite_nx     = pwrite;
        paddr_nx      = paddr;
        pwdata_nx     = pwdata;
        rdata_nx      = rdata;

        case (state)
            IDLE: begin
                if (!hold_off && (req0 || req1)) begin
                    // On contention the requester that did not win last time goes next
                    win           = (req0 && req1) ? ~last_grant : req1;
                    last_grant_nx = win;
                    pwrite_nx     = win ? write1 : write0;
                    paddr_nx      = win ? addr1  : addr0;
                    pwdata_nx     = win ? wdata1 : wdata0;
                    psel_nx       = 1'b1;
                    state_nx      = SETUP;
                end
            end
            SETUP: begin
                penable_nx = 1'b1;
                tcount_nx  = 8'd0;
                state_nx   = ACCESS;
            end
            ACCESS: begin
                if (tcount != 8'hFF)
                    tcount_nx = tcount + 8'd1;
                if (pready) begin
                    psel_nx    = 1'b0;
                    penable_nx = 1'b0;
                    done0_nx   = ~last_grant;
                    done1_nx   = last_grant;
                    err_nx     = pslverr;
                    if (!pwrite)
                        rdata_nx = prdata;
                    gcount_nx  = GAP_LOAD;
                    state_nx   = GAP;
                end else if (TIMEOUT != 8'd0 && tcount == TO_LAST) begin
                    psel_nx    = 1'b0;
                    penable_nx = 1'b0;
                    done0_nx   = ~last_grant;
                    done1_nx   = last_grant;
                    err_nx     = 1'b1;
                    gcount_nx  = GAP_LOAD;
                    state_nx   = GAP;
                end
            end
            GAP: begin
                // Leaving as the count reaches zero lets IDLE grant exactly MIN_GAP cycles after psel fell
                psel_nx = 1'b0;
                if (gcount != 4'd0)
                    gcount_nx = gcount - 4'd1;
                if (gcount <= 4'd1)
                    state_nx = IDLE;
            end
            default: begin
                state_nx   = IDLE;
                psel_nx    = 1'b0;
                penable_nx = 1'b0;
                pwrite_nx  = 1'b0;
                paddr_nx   = '0;
                pwdata_nx  = 32'd0;
            end
        endcase

        busy_nx = (state_nx != IDLE);
    end

endmodule

// File: tb/tb_corereset_sdif_apb_arb.sv
// Directed bench for corereset_sdif_apb_arb: a table of single transfers plus
// hand-written contention, hold-off, timeout and mid-transfer reset sequences.
module tb_corereset_sdif_apb_arb;

    logic        CLK_BASE = 1'b0;
    logic        RESET;
    logic        hold_off;
    logic        req0, req1, write0, write1;
    logic [15:0] addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        done0, done1, err, busy;
    logic [31:0] rdata;
    logic        psel, penable, pwrite;
    logic [15:0] paddr;
    logic [31:0] pwdata, prdata;
    logic        pready, pslverr;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        who;
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        int          waits;
        logic        slverr;
        int          exp_edge;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    corereset_sdif_apb_arb #(
        .ADDR_W (16),
        .MIN_GAP(4),
        .TIMEOUT(8'd8)
    ) dut (
        .CLK_BASE(CLK_BASE),
        .RESET   (RESET),
        .hold_off(hold_off),
        .req0    (req0),
        .req1    (req1),
        .write0  (write0),
        .write1  (write1),
        .addr0   (addr0),
        .addr1   (addr1),
        .wdata0  (wdata0),
        .wdata1  (wdata1),
        .done0   (done0),
        .done1   (done1),
        .err     (err),
        .rdata   (rdata),
        .busy    (busy),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr)
    );

    always #5 CLK_BASE = ~CLK_BASE;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: no response within cycle budget", name);
    endtask

    // One complete transfer from IDLE; leaves the arbiter back in IDLE
    task automatic applyStimulus(input vec_t v);
        bit seen;
        if (v.who) begin
            req1 = 1'b1; write1 = v.wr; addr1 = v.addr; wdata1 = v.wdata;
        end else begin
            req0 = 1'b1; write0 = v.wr; addr0 = v.addr; wdata0 = v.wdata;
        end
        prdata  = v.rd;
        pslverr = v.slverr;
        pready  = 1'b0;
        seen    = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge CLK_BASE);
            if (k == 0) begin
                checkOutput("setup_psel", psel, 1);
                checkOutput("setup_penable", penable, 0);
                checkOutput("setup_busy", busy, 1);
            end
            if (done0 || done1) begin
                seen = 1'b1;
                checkOutput("done_edge", k, v.exp_edge);
                checkOutput("done_who", {done1, done0}, v.who ? 32'd2 : 32'd1);
                checkOutput("done_err", err, v.exp_err);
                checkOutput("done_rdata", rdata, v.exp_rdata);
                checkOutput("done_psel", psel, 0);
                req0 = 1'b0; req1 = 1'b0; pslverr = 1'b0;
            end else if (k >= 1) begin
                checkOutput("access_penable", penable, 1);
                checkOutput("paddr_stable", paddr, v.addr);
                checkOutput("pwrite_stable", pwrite, v.wr);
                if (v.wr)
                    checkOutput("pwdata_stable", pwdata, v.wdata);
            end
            pready = (k + 1 >= 2 + v.waits);
        end
        if (!seen) begin
            failNow("done_wait");
            req0 = 1'b0; req1 = 1'b0;
        end
        @(negedge CLK_BASE);
        checkOutput("done_pulse_end", {done1, done0}, 0);
        checkOutput("gap_psel", psel, 0);
        repeat (2) begin
            @(negedge CLK_BASE);
            checkOutput("gap_psel", psel, 0);
        end
        pready = 1'b1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit          seen;
        bit          raise0, raise1, prev_psel, exp_who;
        int          nxfer, last_fall;

        vecs[0] = '{1'b0, 1'b0, 16'h0010, 32'h0000_0000, 32'hDEADBEEF, 0, 1'b0, 2, 1'b0, 32'hDEADBEEF};
        vecs[1] = '{1'b1, 1'b1, 16'h1234, 32'hCAFEF00D, 32'h1111_1111, 0, 1'b1, 2, 1'b1, 32'hDEADBEEF};
        vecs[2] = '{1'b0, 1'b0, 16'hABCD, 32'h0000_0000, 32'h0BADF00D, 3, 1'b0, 5, 1'b0, 32'h0BADF00D};
        vecs[3] = '{1'b1, 1'b0, 16'hFFFF, 32'h0000_0000, 32'h1234_5678, 1, 1'b1, 3, 1'b1, 32'h1234_5678};
        vecs[4] = '{1'b0, 1'b1, 16'h0002, 32'hA5A5A5A5, 32'h9999_9999, 2, 1'b0, 4, 1'b0, 32'h1234_5678};
        vecs[5] = '{1'b0, 1'b0, 16'h0044, 32'h0000_0000, 32'h7654_3210, 7, 1'b0, 9, 1'b0, 32'h7654_3210};

        RESET = 1'b1; hold_off = 1'b0;
        req0 = 1'b0; req1 = 1'b0; write0 = 1'b0; write1 = 1'b0;
        addr0 = 16'h0; addr1 = 16'h0; wdata0 = 32'h0; wdata1 = 32'h0;
        prdata = 32'h0; pready = 1'b1; pslverr = 1'b0;

        repeat (3) @(negedge CLK_BASE);
        checkOutput("rst_psel", psel, 0);
        checkOutput("rst_penable", penable, 0);
        checkOutput("rst_pwrite", pwrite, 0);
        checkOutput("rst_done", {done1, done0}, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_paddr", paddr, 0);
        checkOutput("rst_pwdata", pwdata, 0);
        checkOutput("rst_rdata", rdata, 0);
        RESET = 1'b0;
        @(negedge CLK_BASE);

        for (int i = 0; i < 6; i++)
            applyStimulus(vecs[i]);

        // Timeout: pready never arrives
        req0 = 1'b1; write0 = 1'b0; addr0 = 16'h0040; prdata = 32'hFFFF0000; pready = 1'b0;
        seen = 1'b0;
        for (int e = 0; e < 30 && !seen; e++) begin
            @(negedge CLK_BASE);
            if (e == 1)
                checkOutput("to_penable", penable, 1);
            if (done0 || done1) begin
                seen = 1'b1;
                checkOutput("to_edge", e, 9);
                checkOutput("to_who", {done1, done0}, 1);
                checkOutput("to_err", err, 1);
                checkOutput("to_rdata", rdata, 32'h7654_3210);
                req0 = 1'b0;
            end
        end
        if (!seen) begin
            failNow("to_wait");
            req0 = 1'b0;
        end
        repeat (3) @(negedge CLK_BASE);
        pready = 1'b1;

        // Hold-off blocks a pending grant, but not a transfer already granted
        hold_off = 1'b1; req1 = 1'b1; write1 = 1'b0; addr1 = 16'h0080; prdata = 32'h0A0B0C0D;
        repeat (20) begin
            @(negedge CLK_BASE);
            checkOutput("ho_psel", psel, 0);
            checkOutput("ho_busy", busy, 0);
        end
        hold_off = 1'b0;
        @(negedge CLK_BASE);
        checkOutput("ho_release_psel", psel, 1);
        hold_off = 1'b1; pready = 1'b0;
        @(negedge CLK_BASE);
        checkOutput("ho_access_penable", penable, 1);
        @(negedge CLK_BASE);
        checkOutput("ho_wait_done", {done1, done0}, 0);
        pready = 1'b1;
        @(negedge CLK_BASE);
        checkOutput("ho_done1", {done1, done0}, 2);
        checkOutput("ho_rdata", rdata, 32'h0A0B0C0D);
        req1 = 1'b0;
        repeat (6) @(negedge CLK_BASE);
        hold_off = 1'b0;
        @(negedge CLK_BASE);

        // Contention: grants alternate with an exact four-cycle gap
        req0 = 1'b1; req1 = 1'b1; write0 = 1'b0; write1 = 1'b0;
        addr0 = 16'h0100; addr1 = 16'h0200; prdata = 32'h55AA55AA; pready = 1'b1;
        exp_who = 1'b0; nxfer = 0; last_fall = -1; prev_psel = 1'b0; raise0 = 1'b0; raise1 = 1'b0;
        for (int e = 0; e < 80 && nxfer < 4; e++) begin
            @(negedge CLK_BASE);
            if (raise0) begin req0 = 1'b1; raise0 = 1'b0; end
            if (raise1) begin req1 = 1'b1; raise1 = 1'b0; end
            if (psel && !prev_psel && last_fall >= 0)
                checkOutput("cont_gap", e - last_fall, 4);
            if (!psel && prev_psel)
                last_fall = e;
            prev_psel = psel;
            if (done0 || done1) begin
                checkOutput("cont_who", {done1, done0}, exp_who ? 32'd2 : 32'd1);
                if (done0) begin req0 = 1'b0; raise0 = 1'b1; end
                else       begin req1 = 1'b0; raise1 = 1'b1; end
                exp_who = ~exp_who;
                nxfer++;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        if (nxfer < 4)
            failNow("cont_count");
        repeat (6) @(negedge CLK_BASE);

        // Reset in ACCESS after a req0 grant; req0 must still win first afterwards
        req0 = 1'b1; write0 = 1'b0; addr0 = 16'h0300; pready = 1'b0;
        repeat (3) @(negedge CLK_BASE);
        checkOutput("mid_penable", penable, 1);
        RESET = 1'b1;
        #1;
        checkOutput("mid_rst_psel", psel, 0);
        checkOutput("mid_rst_penable", penable, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_paddr", paddr, 0);
        checkOutput("mid_rst_rdata", rdata, 0);
        checkOutput("mid_rst_done", {done1, done0}, 0);
        req0 = 1'b0; pready = 1'b1;
        repeat (2) begin
            @(negedge CLK_BASE);
            checkOutput("mid_rst_no_done", {done1, done0}, 0);
        end
        RESET = 1'b0;
        @(negedge CLK_BASE);
        req0 = 1'b1; req1 = 1'b1;
        seen = 1'b0;
        for (int e = 0; e < 20 && !seen; e++) begin
            @(negedge CLK_BASE);
            if (done0 || done1) begin
                seen = 1'b1;
                checkOutput("post_rst_first", {done1, done0}, 1);
                req0 = 1'b0; req1 = 1'b0;
            end
        end
        if (!seen) begin
            failNow("post_rst_wait");
            req0 = 1'b0; req1 = 1'b0;
        end
        repeat (4) @(negedge CLK_BASE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
